fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the program counter, reads one 32-bit word per
// cycle from a combinational program memory, and registers it into the IF/ID
// pipeline register. Handles stall, flush and branch redirect, and enters a
// sticky FAULT state on an illegal fetch address until reset.
//
// Parameters
//   RESET_PC      PC value loaded on reset
//   MEM_BYTES     program memory size in bytes (legal addresses: word aligned,
//                 at most MEM_BYTES-4)
//
// Ports
//   clk           clock, all state changes on its rising edge
//   rst           synchronous active-high reset
//   stall         hold PC, IF/ID and fetch_count
//   flush         load a bubble into IF/ID, PC unchanged
//   branch_taken  redirect PC to branch_target
//   branch_target redirect byte address
//   imem_addr     byte address to program memory (equals PC)
//   imem_data     instruction word returned for imem_addr, same cycle
//   if_id_pc      PC of the registered instruction (0 for a bubble)
//   if_id_instr   registered instruction (NOP for a bubble)
//   if_id_valid   high when IF/ID carries a real fetched instruction
//   fault         high while in FAULT
//   fault_addr    offending byte address captured on fault entry
//   fetch_count   number of valid instructions delivered into IF/ID
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

  function automatic logic is_legal(input logic [31:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= LAST_WORD);
  endfunction

  state_t      state, state_next;
  logic [31:0] pc, pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] if_id_pc_next;
  logic [31:0] if_id_instr_next;
  logic        if_id_valid_next;
  logic [31:0] fault_addr_next;
  logic [31:0] fetch_count_next;
  // Set when the last legal word has just been delivered; the following edge
  // commits the FAULT entry without fetching anything further.
  logic        end_pending, end_pending_next;

  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign fault     = (state == FAULT);

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_next       = state;
    pc_next          = pc;
    if_id_pc_next    = if_id_pc;
    if_id_instr_next = if_id_instr;
    if_id_valid_next = if_id_valid;
    fault_addr_next  = fault_addr;
    fetch_count_next = fetch_count;
    end_pending_next = end_pending;

    unique case (state)
      RUN: begin
        if (end_pending) begin
          state_next       = FAULT;
          fault_addr_next  = pc_plus4;
          end_pending_next = 1'b0;
          if_id_pc_next    = 32'h0;
          if_id_instr_next = NOP;
          if_id_valid_next = 1'b0;
        end else if (branch_taken) begin
          if (is_legal(branch_target)) begin
            pc_next = branch_target;
          end else begin
            state_next      = FAULT;
            fault_addr_next = branch_target;
          end
          if_id_pc_next    = 32'h0;
          if_id_instr_next = NOP;
          if_id_valid_next = 1'b0;
        end else if (stall) begin
          // Everything holds; flush is deliberately ignored while stalled.
        end else if (flush) begin
          if_id_pc_next    = 32'h0;
          if_id_instr_next = NOP;
          if_id_valid_next = 1'b0;
        end else begin
          if_id_pc_next    = pc;
          if_id_instr_next = imem_data;
          if_id_valid_next = 1'b1;
          fetch_count_next = fetch_count + 32'd1;
          if (is_legal(pc_plus4)) begin
            pc_next = pc_plus4;
          end else begin
            end_pending_next = 1'b1;
          end
        end
      end

      FAULT: begin
        if_id_pc_next    = 32'h0;
        if_id_instr_next = NOP;
        if_id_valid_next = 1'b0;
      end

      default: begin
        state_next = RUN;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_instr <= NOP;
      if_id_valid <= 1'b0;
      fault_addr  <= 32'h0;
      fetch_count <= 32'h0;
      end_pending <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_pc    <= if_id_pc_next;
      if_id_instr <= if_id_instr_next;
      if_id_valid <= if_id_valid_next;
      fault_addr  <= fault_addr_next;
      fetch_count <= fetch_count_next;
      end_pending <= end_pending_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Each cycle's expected IF/ID contents are
// pushed to a scoreboard queue when the stimulus is driven and popped after
// the edge. Program memory is a small combinational model in the bench.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        fault;
  logic [31:0] fault_addr;
  logic [31:0] fetch_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } ifid_t;

  ifid_t sb[$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .MEM_BYTES(1024)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_pc     (if_id_pc),
    .if_id_instr  (if_id_instr),
    .if_id_valid  (if_id_valid),
    .fault        (fault),
    .fault_addr   (fault_addr),
    .fetch_count  (fetch_count)
  );

  // Program memory: words 0,4,8 hold 0xA,0xB,0xC; elsewhere a tag of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_000A;
      32'h4:   return 32'h0000_000B;
      32'h8:   return 32'h0000_000C;
      default: return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_ifid(input logic [31:0] pc, input logic [31:0] instr, input logic valid);
    ifid_t e;
    e.pc    = pc;
    e.instr = instr;
    e.valid = valid;
    sb.push_back(e);
  endtask

  task automatic expect_bubble();
    expect_ifid(32'h0, NOP, 1'b0);
  endtask

  // Drive one cycle of inputs, clock once, then compare the scoreboard head.
  task automatic cycle(input logic r, input logic br, input logic [31:0] tgt,
                       input logic st, input logic fl, input string tag);
    ifid_t e;
    rst           = r;
    branch_taken  = br;
    branch_target = tgt;
    stall         = st;
    flush         = fl;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      check({tag, " if_id_pc"},    if_id_pc,            e.pc);
      check({tag, " if_id_instr"}, if_id_instr,         e.instr);
      check({tag, " if_id_valid"}, {31'h0, if_id_valid}, {31'h0, e.valid});
    end
  endtask

  task automatic check_state(input string tag, input logic [31:0] addr, input logic flt,
                             input logic [31:0] faddr, input logic [31:0] cnt);
    check({tag, " imem_addr"},   imem_addr,     addr);
    check({tag, " fault"},       {31'h0, fault}, {31'h0, flt});
    check({tag, " fault_addr"},  fault_addr,    faddr);
    check({tag, " fetch_count"}, fetch_count,   cnt);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    #2;

    // Reset wins over branch, stall and flush on the same edge.
    expect_bubble();
    cycle(1, 1, 32'h40, 1, 1, "reset");
    check_state("reset", 32'h0, 0, 32'h0, 32'h0);

    // Two advances.
    expect_ifid(32'h0, 32'hA, 1);
    cycle(0, 0, 32'h0, 0, 0, "adv0");
    expect_ifid(32'h4, 32'hB, 1);
    cycle(0, 0, 32'h0, 0, 0, "adv1");
    check_state("adv1", 32'h8, 0, 32'h0, 32'd2);

    // Stall two cycles at PC=8, flush high during the second: nothing moves.
    expect_ifid(32'h4, 32'hB, 1);
    cycle(0, 0, 32'h0, 1, 0, "stall0");
    expect_ifid(32'h4, 32'hB, 1);
    cycle(0, 0, 32'h0, 1, 1, "stall1");
    check_state("stall", 32'h8, 0, 32'h0, 32'd2);

    // Third advance completes the 0xA/0xB/0xC run.
    expect_ifid(32'h8, 32'hC, 1);
    cycle(0, 0, 32'h0, 0, 0, "adv2");
    check_state("adv2", 32'hC, 0, 32'h0, 32'd3);

    // Back to PC=8, then branch to 0x40 together with stall and flush.
    expect_bubble();
    cycle(0, 1, 32'h8, 0, 0, "br8");
    check_state("br8", 32'h8, 0, 32'h0, 32'd3);
    expect_bubble();
    cycle(0, 1, 32'h40, 1, 1, "br40");
    check_state("br40", 32'h40, 0, 32'h0, 32'd3);
    expect_ifid(32'h40, mem_word(32'h40), 1);
    cycle(0, 0, 32'h0, 0, 0, "adv40");
    check_state("adv40", 32'h44, 0, 32'h0, 32'd4);

    // Flush alone at PC=0x10 refetches the same address.
    expect_bubble();
    cycle(0, 1, 32'h10, 0, 0, "br10");
    expect_bubble();
    cycle(0, 0, 32'h0, 0, 1, "flush");
    check_state("flush", 32'h10, 0, 32'h0, 32'd4);
    expect_ifid(32'h10, mem_word(32'h10), 1);
    cycle(0, 0, 32'h0, 0, 0, "adv10");
    check_state("adv10", 32'h14, 0, 32'h0, 32'd5);

    // Misaligned branch target faults; inputs ignored for 5 cycles.
    expect_bubble();
    cycle(0, 1, 32'h42, 0, 0, "br42");
    check_state("br42", 32'h14, 1, 32'h42, 32'd5);
    for (int i = 0; i < 5; i++) begin
      expect_bubble();
      cycle(0, i[0], 32'h40, i[1], ~i[0], "inflt");
      check_state("inflt", 32'h14, 1, 32'h42, 32'd5);
    end

    // Reset leaves FAULT, again beating a concurrent branch.
    expect_bubble();
    cycle(1, 1, 32'h80, 0, 0, "rst_flt");
    check_state("rst_flt", 32'h0, 0, 32'h0, 32'h0);

    // Out-of-range target beyond the last word also faults.
    expect_bubble();
    cycle(0, 1, 32'h400, 0, 0, "br400");
    check_state("br400", 32'h0, 1, 32'h400, 32'h0);
    expect_bubble();
    cycle(1, 0, 32'h0, 0, 0, "rst2");
    check_state("rst2", 32'h0, 0, 32'h0, 32'h0);

    // Last legal word: delivered valid, then FAULT at 0x400 on the next edge.
    expect_bubble();
    cycle(0, 1, 32'h3FC, 0, 0, "br3fc");
    check_state("br3fc", 32'h3FC, 0, 32'h0, 32'h0);
    expect_ifid(32'h3FC, mem_word(32'h3FC), 1);
    cycle(0, 0, 32'h0, 0, 0, "adv3fc");
    check_state("adv3fc", 32'h3FC, 0, 32'h0, 32'd1);
    expect_bubble();
    cycle(0, 0, 32'h0, 0, 0, "end_flt");
    check_state("end_flt", 32'h3FC, 1, 32'h400, 32'd1);
    expect_bubble();
    cycle(0, 0, 32'h0, 0, 0, "end_hold");
    check_state("end_hold", 32'h3FC, 1, 32'h400, 32'd1);

    // Reset mid-stall.
    expect_bubble();
    cycle(1, 0, 32'h0, 1, 0, "rst3");
    check_state("rst3", 32'h0, 0, 32'h0, 32'h0);
    expect_bubble();
    cycle(0, 0, 32'h0, 1, 0, "stall_rst");
    check_state("stall_rst", 32'h0, 0, 32'h0, 32'h0);

    check("scoreboard drained", sb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
